// File: rtl/bcd_pkg.sv
// Shared types and constants for the 14-bit to 4-digit BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam int STEPS = 14;
  localparam logic [BIN_W-1:0] BCD_MAX = 14'd9999;
  localparam logic [3:0] OVF_DIGIT = 4'hE;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more.
module bcd_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd4.sv
// Sequential double-dabble converter, 14-bit binary to four BCD digits.
module bin_to_bcd4
  import bcd_pkg::*;
(
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [BIN_W-1:0] BIN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [3:0]       D1,
  output logic [3:0]       D2,
  output logic [3:0]       D3,
  output logic [3:0]       D4
);

  state_t           state;
  state_t           state_n;
  logic [BIN_W-1:0] shift_q;
  logic [BIN_W-1:0] sh_next;
  logic [BCD_W-1:0] scratch_q;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scr_next;
  logic [3:0]       step_q;
  logic             ovf_pend;
  logic             last_step;
  logic             too_big;

  for (genvar g = 0; g < 4; g++) begin : g_adj
    bcd_adjust u_adj (
      .din  (scratch_q[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign scr_next  = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
  assign sh_next   = {shift_q[BIN_W-2:0], 1'b0};
  assign last_step = step_q == 4'(STEPS - 1);
  assign too_big   = BIN > BCD_MAX;
  assign BUSY      = state == SHIFT;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (START) state_n = too_big ? FINISH : SHIFT;
      SHIFT:
        if (last_step) state_n = FINISH;
      FINISH:
        state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // Overflow results are published on the FINISH exit edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      shift_q   <= '0;
      scratch_q <= '0;
      step_q    <= '0;
      ovf_pend  <= 1'b0;
      DONE      <= 1'b0;
      OVF       <= 1'b0;
      D1        <= '0;
      D2        <= '0;
      D3        <= '0;
      D4        <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START && too_big) begin
            ovf_pend <= 1'b1;
          end else if (START) begin
            shift_q   <= BIN;
            scratch_q <= '0;
            step_q    <= '0;
            ovf_pend  <= 1'b0;
          end
        end
        SHIFT: begin
          scratch_q <= scr_next;
          shift_q   <= sh_next;
          step_q    <= step_q + 4'd1;
          if (last_step) begin
            D1   <= scr_next[3:0];
            D2   <= scr_next[7:4];
            D3   <= scr_next[11:8];
            D4   <= scr_next[15:12];
            OVF  <= 1'b0;
            DONE <= 1'b1;
          end
        end
        FINISH: begin
          if (ovf_pend) begin
            D1       <= OVF_DIGIT;
            D2       <= OVF_DIGIT;
            D3       <= OVF_DIGIT;
            D4       <= OVF_DIGIT;
            OVF      <= 1'b1;
            DONE     <= 1'b1;
            ovf_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed self-checking bench for bin_to_bcd4.
module tb_bin_to_bcd4;

  logic        CLK;
  logic        CLR;
  logic        START;
  logic [13:0] BIN;
  logic        BUSY;
  logic        DONE;
  logic        OVF;
  logic [3:0]  D1;
  logic [3:0]  D2;
  logic [3:0]  D3;
  logic [3:0]  D4;

  int tests;
  int fails;

  bin_to_bcd4 dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .START (START),
    .BIN   (BIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OVF   (OVF),
    .D1    (D1),
    .D2    (D2),
    .D3    (D3),
    .D4    (D4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {D4, D3, D2, D1};
  endfunction

  task automatic run_conv(input string tag, input logic [13:0] b,
                          input logic [15:0] exp_d, input logic exp_ovf,
                          input int exp_lat, input int exp_busy);
    int lat;
    int busy;
    int n;
    lat  = -1;
    busy = 0;
    n    = 0;
    START = 1'b1;
    BIN   = b;
    while (lat < 0 && n < 40) begin
      @(negedge CLK);
      n++;
      START = 1'b0;
      BIN   = ~b;
      if (BUSY) busy++;
      if (DONE) lat = n;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy, exp_busy);
    check({tag, "_dig"}, {16'h0, digits()}, {16'h0, exp_d});
    check({tag, "_ovf"}, {31'h0, OVF}, {31'h0, exp_ovf});
    @(negedge CLK);
    check({tag, "_pulse"}, {31'h0, DONE}, 32'h0);
  endtask

  initial begin
    int dones;
    int first;
    int last;
    int gaps_bad;
    tests = 0;
    fails = 0;
    CLR   = 1'b1;
    START = 1'b0;
    BIN   = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    check("rst_done", {31'h0, DONE}, 32'h0);
    check("rst_ovf", {31'h0, OVF}, 32'h0);
    check("rst_dig", {16'h0, digits()}, 32'h0);

    CLR = 1'b0;
    run_conv("bin0", 14'd0, 16'h0000, 1'b0, 15, 14);
    run_conv("bin1234", 14'd1234, 16'h1234, 1'b0, 15, 14);
    run_conv("bin9999", 14'd9999, 16'h9999, 1'b0, 15, 14);
    run_conv("bin10000", 14'd10000, 16'hEEEE, 1'b1, 2, 0);
    run_conv("bin16383", 14'd16383, 16'hEEEE, 1'b1, 2, 0);
    run_conv("bin59", 14'd59, 16'h0059, 1'b0, 15, 14);

    // second request during SHIFT must be dropped
    dones = 0;
    first = -1;
    START = 1'b1;
    BIN   = 14'd42;
    for (int n = 1; n <= 25; n++) begin
      @(negedge CLK);
      START = (n == 5);
      BIN   = (n == 5) ? 14'd7 : 14'd0;
      if (DONE) begin
        dones++;
        if (first < 0) first = n;
      end
    end
    check("lost_dones", dones, 1);
    check("lost_lat", first, 15);
    check("lost_dig", {16'h0, digits()}, 32'h0042);

    // abort mid-conversion
    START = 1'b1;
    BIN   = 14'd5678;
    for (int n = 1; n <= 7; n++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    @(negedge CLK);
    CLR = 1'b1;
    #1;
    check("abort_busy", {31'h0, BUSY}, 32'h0);
    check("abort_dig", {16'h0, digits()}, 32'h0);
    check("abort_ovf", {31'h0, OVF}, 32'h0);
    @(negedge CLK);
    CLR   = 1'b0;
    dones = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    check("abort_quiet", dones, 0);
    run_conv("bin5678", 14'd5678, 16'h5678, 1'b0, 15, 14);

    // START held high: re-accept every 16 cycles
    dones    = 0;
    first    = -1;
    last     = -1;
    gaps_bad = 0;
    START = 1'b1;
    BIN   = 14'd321;
    for (int n = 1; n <= 50; n++) begin
      @(negedge CLK);
      if (DONE) begin
        dones++;
        if (first < 0) first = n;
        if (last >= 0 && n - last != 16) gaps_bad++;
        if (digits() !== 16'h0321) gaps_bad++;
        last = n;
      end
    end
    START = 1'b0;
    check("hold_dones", dones, 3);
    check("hold_first", first, 15);
    check("hold_bad", gaps_bad, 0);
    check("hold_dig", {16'h0, digits()}, 32'h0321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
